// File: rtl/huffman_stream_serializer.sv
// Serializes Huffman codes from a writable codebook for a FIFO'd stream of symbol indices.
// Latency: a symbol pushed at edge k is loaded at edge k+1; its first bit is valid after k+1; 1 bit/cycle.
// Backpressure: Out/Out_last/state hold while Out_valid && !Out_ready; Sym_ready drops when the FIFO is full.
module huffman_stream_serializer #(
  parameter int NUM_SYM   = 10,
  parameter int CODE_W    = 16,
  parameter int LEN_W     = 5,
  parameter int DEPTH     = 8,
  parameter bit LSB_FIRST = 1'b0,
  parameter int SYM_W     = $clog2(NUM_SYM),
  parameter int CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic              Clk_in,
  input  logic              Rst,
  input  logic              Cb_we,
  input  logic [SYM_W-1:0]  Cb_addr,
  input  logic [LEN_W-1:0]  Cb_len,
  input  logic [CODE_W-1:0] Cb_code,
  input  logic              Sym_valid,
  output logic              Sym_ready,
  input  logic [SYM_W-1:0]  Sym_in,
  input  logic              Sym_last,
  output logic              Out,
  output logic              Out_valid,
  input  logic              Out_ready,
  output logic              Out_last,
  output logic              Done,
  output logic              Err,
  output logic              Busy,
  output logic [CNT_W-1:0]  Fifo_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [SYM_W:0]   NUM_SYM_V = (SYM_W+1)'(NUM_SYM);
  localparam logic [LEN_W-1:0] CODE_W_V  = LEN_W'(CODE_W);
  localparam logic [CNT_W-1:0] DEPTH_V   = CNT_W'(DEPTH);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  logic [LEN_W-1:0]  cb_len  [NUM_SYM];
  logic [CODE_W-1:0] cb_code [NUM_SYM];
  logic [SYM_W-1:0]  fifo_sym  [DEPTH];
  logic              fifo_last [DEPTH];

  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  state_t            state_q, state_d;
  logic [CODE_W-1:0] sr;
  logic [LEN_W-1:0]  rem;
  logic              last_q, done_q, err_q;

  logic [SYM_W-1:0]  head_sym;
  logic              head_last, sym_ok, invalid;
  logic [LEN_W-1:0]  ent_len;
  logic [CODE_W-1:0] ent_code, masked, load_val;
  logic              out_valid, cur_bit, accept, final_acc, fifo_ne, pop, load, push;

  // Head-of-FIFO codebook lookup and validity; a load always sees the pre-write codebook contents.
  always_comb begin
    head_sym  = fifo_sym[rd_ptr];
    head_last = fifo_last[rd_ptr];
    sym_ok    = {1'b0, head_sym} < NUM_SYM_V;
    ent_len   = '0;
    ent_code  = '0;
    if (sym_ok) begin
      ent_len  = cb_len[head_sym];
      ent_code = cb_code[head_sym];
    end
    invalid  = !sym_ok || (ent_len == '0) || (ent_len > CODE_W_V);
    // Bits above len are cleared so stale upper code bits never leak out.
    masked   = ent_code & ~({CODE_W{1'b1}} << ent_len);
    load_val = LSB_FIRST ? masked : (masked << (CODE_W_V - ent_len));
  end

  assign out_valid = (state_q == S_SHIFT);
  assign cur_bit   = LSB_FIRST ? sr[0] : sr[CODE_W-1];
  assign accept    = out_valid && Out_ready;
  assign final_acc = accept && (rem == LEN_W'(1));
  assign fifo_ne   = (count != '0);
  // Pop from IDLE, or on the final accepted bit so back-to-back symbols have no bubble.
  assign pop       = fifo_ne && ((state_q == S_IDLE) || final_acc);
  assign load      = pop && !invalid;
  assign Sym_ready = (count < DEPTH_V) && !Rst;
  assign push      = Sym_valid && Sym_ready;

  assign Out        = out_valid & cur_bit;
  assign Out_valid  = out_valid;
  assign Out_last   = out_valid && last_q && (rem == LEN_W'(1));
  assign Done       = done_q;
  assign Err        = err_q;
  assign Busy       = fifo_ne || out_valid;
  assign Fifo_count = count;

  // Codebook storage: reset clears every entry to length 0; out-of-range writes are dropped.
  always_ff @(posedge Clk_in) begin
    if (Rst) begin
      for (int i = 0; i < NUM_SYM; i++) begin
        cb_len[i]  <= '0;
        cb_code[i] <= '0;
      end
    end else if (Cb_we && ({1'b0, Cb_addr} < NUM_SYM_V)) begin
      cb_len[Cb_addr]  <= Cb_len;
      cb_code[Cb_addr] <= Cb_code;
    end
  end

  // FIFO payload storage; contents are meaningful only between the pointers.
  always_ff @(posedge Clk_in) begin
    if (push) begin
      fifo_sym[wr_ptr]  <= Sym_in;
      fifo_last[wr_ptr] <= Sym_last;
    end
  end

  // FSM state register.
  always_ff @(posedge Clk_in) begin
    if (Rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state: invalid symbols are dropped and leave the FSM in IDLE for one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (load) state_d = S_SHIFT;
      S_SHIFT: if (final_acc) state_d = load ? S_SHIFT : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO pointers/occupancy, shift register, frame-end and error flags.
  always_ff @(posedge Clk_in) begin
    if (Rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      sr     <= '0;
      rem    <= '0;
      last_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (load) begin
        sr     <= load_val;
        rem    <= ent_len;
        last_q <= head_last;
      end else if (accept) begin
        sr  <= LSB_FIRST ? (sr >> 1) : (sr << 1);
        rem <= rem - LEN_W'(1);
      end
      done_q <= (accept && Out_last) || (pop && invalid && head_last);
      if (pop && invalid) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_huffman_stream_serializer.sv
// Directed bench: MSB-first instance with 16 entries, LSB-first instance with 10 entries, shared stimulus.
// Accepted bits are captured on the falling edge and compared with hand-computed codes.
// Out_ready is toggled and held low to exercise stalls and FIFO saturation.
module tb_huffman_stream_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, cb_we, sym_valid, sym_last, out_ready;
  logic [3:0]  cb_addr, sym_in;
  logic [4:0]  cb_len;
  logic [15:0] cb_code;

  logic       sym_ready, out_bit, out_valid, out_last, done, err, busy;
  logic [3:0] fifo_count;
  logic       l_sym_ready, l_out, l_out_valid, l_out_last, l_done, l_err, l_busy;
  logic [3:0] l_fifo_count;

  huffman_stream_serializer #(.NUM_SYM(16), .LSB_FIRST(1'b0)) u_dut (
    .Clk_in(clk), .Rst(rst), .Cb_we(cb_we), .Cb_addr(cb_addr), .Cb_len(cb_len), .Cb_code(cb_code),
    .Sym_valid(sym_valid), .Sym_ready(sym_ready), .Sym_in(sym_in), .Sym_last(sym_last),
    .Out(out_bit), .Out_valid(out_valid), .Out_ready(out_ready), .Out_last(out_last),
    .Done(done), .Err(err), .Busy(busy), .Fifo_count(fifo_count));

  huffman_stream_serializer #(.NUM_SYM(10), .LSB_FIRST(1'b1)) u_lsb (
    .Clk_in(clk), .Rst(rst), .Cb_we(cb_we), .Cb_addr(cb_addr), .Cb_len(cb_len), .Cb_code(cb_code),
    .Sym_valid(sym_valid), .Sym_ready(l_sym_ready), .Sym_in(sym_in), .Sym_last(sym_last),
    .Out(l_out), .Out_valid(l_out_valid), .Out_ready(out_ready), .Out_last(l_out_last),
    .Done(l_done), .Err(l_err), .Busy(l_busy), .Fifo_count(l_fifo_count));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int hold_viol = 0;
  int push_cyc = 0;
  bit stall_prev = 1'b0;
  bit prev_out, prev_last;
  bit q_bit[$];
  bit q_last[$];
  int q_cyc[$];
  bit l_bit[$];
  bit l_last[$];

  logic [4:0]  tbl_len  [10] = '{5'd4, 5'd6, 5'd6, 5'd8, 5'd6, 5'd8, 5'd10, 5'd8, 5'd10, 5'd6};
  logic [15:0] tbl_code [10] = '{16'h001, 16'h007, 16'h001, 16'h008, 16'h005,
                                 16'h009, 16'h001, 16'h001, 16'h000, 16'h006};

  always @(posedge clk) cyc <= cyc + 1;

  // Capture accepted bits, Done pulses and stall-hold behaviour away from the active edge.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      q_bit.push_back(out_bit);
      q_last.push_back(out_last);
      q_cyc.push_back(cyc);
    end
    if (l_out_valid && out_ready) begin
      l_bit.push_back(l_out);
      l_last.push_back(l_out_last);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (stall_prev && (!out_valid || out_bit !== prev_out || out_last !== prev_last)) hold_viol++;
    stall_prev = out_valid && !out_ready;
    prev_out   = out_bit;
    prev_last  = out_last;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    q_bit.delete();
    q_last.delete();
    q_cyc.delete();
    l_bit.delete();
    l_last.delete();
  endtask

  task automatic cb_write(input logic [3:0] a, input logic [4:0] l, input logic [15:0] c);
    cb_we = 1'b1; cb_addr = a; cb_len = l; cb_code = c;
    tick();
    cb_we = 1'b0;
  endtask

  task automatic push(input logic [3:0] s, input logic l);
    bit rdy;
    bit ok;
    ok = 1'b0;
    sym_valid = 1'b1; sym_in = s; sym_last = l;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      rdy = sym_ready;
      tick();
      if (rdy) begin
        ok = 1'b1;
        push_cyc = cyc;
      end
    end
    sym_valid = 1'b0; sym_last = 1'b0;
    if (!ok) check("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done(input int target, input int bound, input string tag);
    for (int i = 0; i < bound && done_cnt < target; i++) tick();
    check(tag, 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic pack(input bit lsb_inst, output logic [31:0] v, output logic [31:0] lm);
    v = '0;
    lm = '0;
    if (lsb_inst) begin
      foreach (l_bit[i]) begin
        v  = {v[30:0], l_bit[i]};
        lm = {lm[30:0], l_last[i]};
      end
    end else begin
      foreach (q_bit[i]) begin
        v  = {v[30:0], q_bit[i]};
        lm = {lm[30:0], q_last[i]};
      end
    end
  endtask

  initial begin
    logic [31:0] v, lm;
    int p0, base, nacc, nerr, idx;
    bit rdy;
    bit exp_q[$];
    bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    rst = 1'b1; cb_we = 1'b0; cb_addr = '0; cb_len = '0; cb_code = '0;
    sym_valid = 1'b0; sym_in = '0; sym_last = 1'b0; out_ready = 1'b1;
    tick(); tick();

    // Reset state.
    check("rst_sym_ready", 32'(sym_ready), 32'd0);
    check("rst_lsb_sym_ready", 32'(l_sym_ready), 32'd0);
    check("rst_outs", {25'd0, out_bit, out_valid, out_last, done, err, busy, l_busy}, 32'd0);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("rst_lsb_count_done", {l_fifo_count, l_done, l_err}, 32'd0);
    rst = 1'b0;
    tick();
    check("post_rst_sym_ready", 32'(sym_ready), 32'd1);

    for (int i = 0; i < 10; i++) cb_write(4'(i), tbl_len[i], tbl_code[i]);
    cb_write(4'd11, 5'd20, 16'h00ff);

    // Three symbols back-to-back, MSB first and LSB first.
    clear_q(); base = done_cnt;
    push(4'd0, 1'b0); p0 = push_cyc;
    push(4'd1, 1'b0);
    push(4'd2, 1'b1);
    wait_done(base + 1, 60, "t1_done_timeout");
    tick(); tick();
    pack(1'b0, v, lm);
    check("t1_nbits", 32'(q_bit.size()), 32'd16);
    check("t1_bits", v, 32'h11C1);
    check("t1_last_pos", lm, 32'h0001);
    if (q_cyc.size() == 16) begin
      check("t1_contiguous", 32'(q_cyc[15] - q_cyc[0]), 32'd15);
      check("t1_first_latency", 32'(q_cyc[0] - p0), 32'd1);
      check("t1_done_timing", 32'(done_cyc - q_cyc[15]), 32'd1);
    end
    check("t1_done_single", 32'(done_cnt - base), 32'd1);
    check("t1_err", {30'd0, err, l_err}, 32'd0);
    pack(1'b1, v, lm);
    check("t1_lsb_bits", v, 32'h8E20);

    // Single symbol, last.
    clear_q(); base = done_cnt;
    push(4'd0, 1'b1);
    wait_done(base + 1, 30, "t2_done_timeout");
    pack(1'b0, v, lm);
    check("t2_msb_bits", v, 32'h1);
    pack(1'b1, v, lm);
    check("t2_lsb_bits", v, 32'h8);
    check("t2_lsb_last", lm, 32'h1);
    check("t2_lsb_nbits", 32'(l_bit.size()), 32'd4);

    // Intermittent Out_ready during symbol 3.
    clear_q(); base = done_cnt; hold_viol = 0;
    out_ready = 1'b0;
    push(4'd3, 1'b1);
    for (int i = 0; i < 80 && done_cnt <= base; i++) begin
      out_ready = pat[i % 4];
      tick();
    end
    check("t3_done", 32'(done_cnt - base), 32'd1);
    pack(1'b0, v, lm);
    check("t3_nbits", 32'(q_bit.size()), 32'd8);
    check("t3_bits", v, 32'h08);
    check("t3_last", lm, 32'h01);
    check("t3_hold", 32'(hold_viol), 32'd0);

    // Saturate the FIFO with the sink stalled.
    out_ready = 1'b0; clear_q(); base = done_cnt; idx = 0;
    for (int i = 0; i < 14; i++) begin
      sym_valid = 1'b1; sym_in = 4'(idx); sym_last = (idx == 8);
      @(negedge clk);
      rdy = sym_ready;
      tick();
      if (rdy) idx++;
    end
    sym_valid = 1'b0; sym_last = 1'b0;
    nacc = idx;
    check("t4_accepted", 32'(nacc), 32'd9);
    check("t4_count_full", 32'(fifo_count), 32'd8);
    check("t4_ready_low", 32'(sym_ready), 32'd0);
    check("t4_busy_valid", {30'd0, busy, out_valid}, 32'd3);
    exp_q.delete();
    for (int s = 0; s < 9; s++)
      for (int b = int'(tbl_len[s]) - 1; b >= 0; b--) exp_q.push_back(tbl_code[s][b]);
    out_ready = 1'b1;
    wait_done(base + 1, 150, "t4_done_timeout");
    check("t4_nbits", 32'(q_bit.size()), 32'd66);
    nerr = 0;
    foreach (exp_q[i]) if (i >= q_bit.size() || q_bit[i] != exp_q[i]) nerr++;
    check("t4_bit_errors", 32'(nerr), 32'd0);
    check("t4_count_empty", 32'(fifo_count), 32'd0);

    // Invalid symbols between valid ones.
    check("t5_err_before", 32'(err), 32'd0);
    clear_q(); base = done_cnt;
    push(4'd1, 1'b0);
    push(4'd10, 1'b0);
    push(4'd12, 1'b0);
    push(4'd11, 1'b0);
    push(4'd2, 1'b1);
    wait_done(base + 1, 60, "t5_done_timeout");
    pack(1'b0, v, lm);
    check("t5_nbits", 32'(q_bit.size()), 32'd12);
    check("t5_bits", v, 32'h1C1);
    check("t5_last", lm, 32'h001);
    check("t5_err", {30'd0, err, l_err}, 32'd3);
    pack(1'b1, v, lm);
    check("t5_lsb_bits", v, 32'hE20);
    base = done_cnt; nacc = q_bit.size();
    push(4'd12, 1'b1);
    wait_done(base + 1, 20, "t5_invalid_last_done");
    tick(); tick();
    check("t5_no_bits", 32'(q_bit.size()), 32'(nacc));
    check("t5_err_held", 32'(err), 32'd1);

    // Reset mid-symbol 6 with symbol 7 queued.
    clear_q();
    push(4'd6, 1'b0);
    push(4'd7, 1'b1);
    tick(); tick();
    rst = 1'b1;
    #1;
    check("t6_ready_in_rst", 32'(sym_ready), 32'd0);
    tick();
    check("t6_outs", {25'd0, out_bit, out_valid, out_last, done, err, busy, l_err}, 32'd0);
    check("t6_count", 32'(fifo_count), 32'd0);
    rst = 1'b0;
    tick();
    check("t6_ready_after", 32'(sym_ready), 32'd1);
    clear_q(); base = done_cnt;
    push(4'd0, 1'b1);
    wait_done(base + 1, 20, "t6_done_timeout");
    tick();
    check("t6_cleared_err", {30'd0, err, l_err}, 32'd3);
    check("t6_no_bits", 32'(q_bit.size() + l_bit.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
